// File: rtl/mem_pkg.sv
// Shared widths and FSM state encoding for the block memory responder.
package mem_pkg;
  localparam int ADDR_W   = 16;
  localparam int BLOCK_W  = 64;
  localparam int OFFSET_W = 3;
  localparam int INDEX_W  = 13;
  localparam int BYTES    = BLOCK_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mem_storage_array.sv
// 8192 x 64-bit block store: registered block read, byte-lane synchronous write.
module mem_storage_array
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [BYTES-1:0]   wr_be,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [BLOCK_W-1:0] mem [0:(1<<INDEX_W)-1];

  // No reset on the array: contents survive a controller reset.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_idx];
    for (int k = 0; k < BYTES; k++) begin
      if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

endmodule

// File: rtl/block_mem_responder.sv
// Fixed-latency memory responder: block fetch or byte write-through, one at a time.
//   state | meaning
//   IDLE  | waiting for req; accepts on the edge req is seen
//   WAIT  | latency counter running, request latched
//   DONE  | ready pulse; write byte commits on the exit edge
module block_mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [7:0]         data_in,
  output logic [BLOCK_W-1:0] block_out,
  output logic               ready,
  output logic               busy
);

  state_t              state;
  logic [3:0]          cnt;
  logic [INDEX_W-1:0]  lat_idx;
  logic [OFFSET_W-1:0] lat_off;
  logic [7:0]          lat_data;
  logic                lat_wr;
  logic [BLOCK_W-1:0]  hold_blk;
  logic [BLOCK_W-1:0]  rd_data;
  logic [INDEX_W-1:0]  rd_idx;
  logic [BYTES-1:0]    wr_be;

  // Read the incoming index on the accept edge so LATENCY=1 has data in DONE.
  assign rd_idx = (state == IDLE && req) ? addr[ADDR_W-1:OFFSET_W] : lat_idx;
  assign wr_be  = (state == DONE && lat_wr && reset_n) ? (BYTES'(1) << lat_off) : '0;
  assign block_out = (state == DONE && !lat_wr) ? rd_data : hold_blk;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      hold_blk <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_idx  <= addr[ADDR_W-1:OFFSET_W];
            lat_off  <= addr[OFFSET_W-1:0];
            lat_data <= data_in;
            lat_wr   <= wr_en;
            cnt      <= 4'(LATENCY - 1);
            busy     <= 1'b1;
            if (LATENCY == 1) begin
              state <= DONE;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
            ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
          if (!lat_wr) hold_blk <= rd_data;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_storage_array u_store (
    .clk     (clk),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_idx  (lat_idx),
    .wr_be   (wr_be),
    .wr_data ({BYTES{lat_data}})
  );

endmodule

// File: doc/block_mem_responder.md
BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning the number of clk cycles from request acceptance to ready (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req, input, 1 bit: cache requests a memory transaction.
REQ-005 The block SHALL have port wr_en, input, 1 bit: qualifies req; 1 = byte write-through, 0 = block fetch.
REQ-006 The block SHALL have port addr, input, 16 bits: byte address, split as block index [15:3] and byte offset [2:0].
REQ-007 The block SHALL have port data_in, input, 8 bits: write byte.
REQ-008 The block SHALL have port block_out, output, 64 bits: fetched block; byte offset k on bits [8k+7:8k].
REQ-009 The block SHALL have port ready, output, 1 bit: one-cycle completion pulse for the current transaction.
REQ-010 The block SHALL have port busy, output, 1 bit: a transaction is in flight, and new requests are ignored.

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT and DONE.
REQ-012 In IDLE with req=1 at a rising edge, the block SHALL accept the request, latch addr, data_in and wr_en, load the latency counter with LATENCY-1, and enter WAIT (or DONE directly if LATENCY=1).
REQ-013 In WAIT, the block SHALL decrement the counter each cycle and enter DONE on the edge where the counter equals 0.
REQ-014 ready SHALL be 1 exactly during the DONE cycle, which is LATENCY cycles after the accepting edge; the FSM SHALL return to IDLE on the following edge.
REQ-015 busy SHALL be 1 in WAIT and DONE and 0 in IDLE.
REQ-016 req asserted while busy=1 SHALL be ignored, with no queuing; the requester must hold req until it sees ready.
REQ-017 For a block fetch, block_out SHALL present the 8 bytes of the latched block index in the DONE cycle, and SHALL hold that value until the next fetch completes.
REQ-018 For a write, the latched byte SHALL be committed at the latched address on the DONE edge only; block_out SHALL be unchanged by writes.
REQ-019 req=1 in the DONE cycle SHALL NOT be accepted; the earliest acceptance SHALL be the first IDLE cycle, giving a back-to-back spacing of LATENCY+1 cycles.
REQ-020 A fetch accepted after a write's DONE cycle SHALL return the written byte (read-after-write coherent).
REQ-021 Address wrap SHALL NOT occur: the full 16-bit space (8192 blocks of 64 bits) is backed by storage.
REQ-022 X on wr_en or addr while req=0 SHALL have no effect.

Reset
REQ-023 With reset_n=0 at a rising edge, the block SHALL set the FSM to IDLE, the counter to 0, ready=0, busy=0 and block_out=64'h0.
REQ-024 A reset arriving mid-transaction SHALL abort it: no byte is committed and no ready pulse is issued.
REQ-025 Storage contents SHALL NOT be cleared by reset; initial contents are zero in simulation only.

Structure
REQ-026 Package mem_pkg SHALL hold ADDR_W=16, BLOCK_W=64, OFFSET_W=3, INDEX_W=13 and the FSM state enum.
REQ-027 Storage SHALL be a sub-module mem_storage_array: 8192x64 bits, with a synchronous byte-lane write enable and a registered block read.
REQ-028 The FSM, counter and latched-request registers SHALL live in block_mem_responder.

Verification
REQ-029 Reset-mid-op: write req with addr=16'h0008, data_in=8'h3C; assert reset_n=0 two cycles later -> no ready pulse; a later fetch of 16'h0008 returns byte0=8'h00.
REQ-030 Write-then-fetch (LATENCY=4): write 8'hA5 to 16'h1234 -> ready 4 cycles after acceptance; then fetch 16'h1230 -> block_out[39:32]=8'hA5, other bytes 8'h00.
REQ-031 Busy drop: second req asserted 2 cycles after an accepted fetch -> ignored; exactly one ready pulse; busy stays high for 4 cycles.
REQ-032 Boundary address: write 8'hFF to 16'hFFFF, then fetch 16'hFFF8 -> block_out[63:56]=8'hFF, no aliasing at 16'h0007.
REQ-033 LATENCY=1 build: fetch with req held high continuously -> ready every 2nd cycle; block_out correct on each pulse.
REQ-034 Hold check: fetch 16'h0100, then perform a write to 16'h0100 -> block_out keeps the pre-write data until the next fetch completes.
